// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with one-outstanding imem reads, 2-entry prefetch FIFO and NOP bubbles
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     NOP      = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic            i_imem_valid,
    input  logic [15:0]     i_imem_data,
    output logic [15:0]     o_ir_id,
    output logic [PC_W-1:0] o_pc_id,
    output logic            o_ir_valid
);
    logic [PC_W-1:0] fpc, req_addr;
    logic            out, kill;
    logic [1:0]      count;
    logic [15:0]     fifo_data [2];
    logic [PC_W-1:0] fifo_addr [2];
    logic            accept, resp, live, bypass, push, pop, widx;

    assign o_imem_req  = !out && ((count + 2'(out)) < 2'd2) && !i_redirect;
    assign o_imem_addr = fpc;
    assign accept      = o_imem_req && i_imem_ack;
    assign resp        = out && i_imem_valid;
    assign live        = resp && !kill && !i_redirect;
    assign bypass      = live && (count == 2'd0) && !i_stall;
    assign push        = live && !bypass;
    assign pop         = !i_stall && !i_redirect && (count != 2'd0);
    assign widx        = pop ? 1'b0 : count[0];

    // Fetch PC, in-flight request address, and outstanding/kill tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            out      <= 1'b0;
            kill     <= 1'b0;
        end else begin
            fpc      <= i_redirect ? i_redirect_pc : accept ? fpc + PC_W'(1) : fpc;
            req_addr <= accept ? fpc : req_addr;
            out      <= accept || (out && !i_imem_valid);
            kill     <= out && !i_imem_valid && (kill || i_redirect);
        end
    end

    // FIFO occupancy; a redirect discards everything buffered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= 2'd0;
        else
            count <= i_redirect ? 2'd0 : count + 2'(push) - 2'(pop);
    end

    // FIFO storage: entry 0 is the head, a pop shifts entry 1 down before the push lands
    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_data[0] <= fifo_data[1];
            fifo_addr[0] <= fifo_addr[1];
        end
        if (push) begin
            fifo_data[widx] <= i_imem_data;
            fifo_addr[widx] <= req_addr;
        end
    end

    // Instruction register to ID: FIFO head first, then bypass word, else a NOP bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ir_id    <= NOP;
            o_pc_id    <= RESET_PC;
            o_ir_valid <= 1'b0;
        end else if (i_redirect) begin
            o_ir_id    <= NOP;
            o_ir_valid <= 1'b0;
        end else if (!i_stall) begin
            o_ir_id    <= (count != 2'd0) ? fifo_data[0] : bypass ? i_imem_data : NOP;
            o_pc_id    <= (count != 2'd0) ? fifo_addr[0] : bypass ? req_addr : o_pc_id;
            o_ir_valid <= (count != 2'd0) || bypass;
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit pipeline. It drives the instruction register consumed by the ID-stage control logic and honours the stall and redirect signals coming back from it. The block issues word-addressed reads to instruction memory over a request/acknowledge/valid interface with one request outstanding. Fetched words are buffered in a 2-entry prefetch FIFO, and a NOP bubble is inserted whenever no instruction is available.

## Interface
Parameters:
- PC_W, 16, fetch address width
- RESET_PC, 16'h0000, first fetch address after reset
- NOP, 16'h0000, encoding inserted as bubble

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_stall  in  1  hold o_ir_id/o_pc_id (ID stage stalled)
- i_redirect  in  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  in  PC_W  new fetch address
- o_imem_req  out  1  read request
- o_imem_addr  out  PC_W  read address (= fetch PC)
- i_imem_ack  in  1  request accepted this cycle
- i_imem_valid  in  1  read data valid
- i_imem_data  in  16  instruction word
- o_ir_id  out  16  instruction register to ID stage
- o_pc_id  out  PC_W  address of o_ir_id
- o_ir_valid  out  1  o_ir_id holds a fetched instruction (0 = bubble)

## Operation
State:
- fpc (fetch PC)
- out (request outstanding)
- kill (discard the pending response)
- 2-entry FIFO of {data, addr} with count 0..2
- output registers o_ir_id, o_pc_id, o_ir_valid
- Per outstanding request, the block also holds its address in a register (req_addr).

Request issue:
- o_imem_req = !out & (count + out < 2) & !i_redirect, with the request registered as combinational from state.
- o_imem_addr = fpc at all times.
- Accept condition is o_imem_req & i_imem_ack. On accept: req_addr <= fpc, fpc <= fpc + 1 (wraps modulo 2^PC_W, 16'hFFFF -> 16'h0000), out <= 1.

Response:
- i_imem_valid counts only when out = 1; otherwise it is ignored. A response clears out and kill.
- If kill = 1, the word is dropped.
- Otherwise, when FIFO is empty and !i_stall, the word bypasses the FIFO into the output registers. In every other case it is pushed into the FIFO.

Output update, when !i_stall and !i_redirect:
- FIFO non-empty: pop head into o_ir_id/o_pc_id and set o_ir_valid = 1.
- Else bypass word present: load it the same way.
- Else: o_ir_id = NOP, o_ir_valid = 0, o_pc_id unchanged.
- When i_stall: outputs hold. Responses still push into the FIFO; the room rule guarantees space.

Redirect (priority over stall and response):
- FIFO count <= 0, fpc <= i_redirect_pc, o_ir_id <= NOP, o_ir_valid <= 0.
- If out = 1, or a valid response arrives in the same cycle, it is not written anywhere. If out remains 1 afterwards, kill <= 1.
- No request is issued while i_redirect = 1.

## Timing
Reset values:
- fpc = RESET_PC, out = 0, kill = 0, count = 0
- o_ir_id = NOP, o_pc_id = RESET_PC, o_ir_valid = 0
- o_imem_req = 1 in the first cycle after rst deasserts

Latency:
- Accept in cycle N, valid in cycle N+k (k >= 1): o_ir_id updates at the edge ending N+k, so it is visible in N+k+1 when not stalled.
- Next request may issue in cycle N+k+1 at the earliest.
- Throughput with k = 1: one instruction every 2 cycles.

Boundary conditions:
- FIFO full (count = 2): no requests until a pop.
- Stall held indefinitely: at most 2 words buffered; outputs frozen.
- Redirect with out = 1: exactly one killed response is discarded. The first request to the new PC issues the cycle after that response.
- Redirect and stall together: redirect wins; output becomes NOP.
- rst asserted mid-request: all state returns to reset values immediately. A late i_imem_valid arriving after release is ignored because out = 0.

## Test plan
- Reset release, memory with k = 1 returning mem[a] = 16'h1000 + a: o_ir_id sequence 1000, NOP, 1001, NOP, 1002 with o_pc_id 0, -, 1, -, 2.
- i_stall high for 6 cycles after o_ir_id = 1001: o_ir_id holds 1001; exactly 2 words buffered and o_imem_req = 0. After release, 1002 and 1003 appear on consecutive cycles.
- Redirect to 16'h0040 while a request to 16'h0005 is outstanding (k = 3): 1005 never appears on o_ir_id. The next request addresses 0x0040, and o_ir_id = 1040 with o_pc_id = 0x0040.
- RESET_PC = 16'hFFFE: fetch addresses FFFE, FFFF, 0000; o_pc_id wraps to 0.
- Redirect and stall asserted in the same cycle with 2 words buffered: next cycle o_ir_id = NOP, o_ir_valid = 0, FIFO empty.
- rst pulsed low while out = 1, valid returned 1 cycle after release: response ignored; first o_ir_id = mem[RESET_PC].
